// File: rtl/unison_scan_sequencer.sv
// unison_scan_sequencer: time-shares the host readout path across the
// digital_unison channels. Each enabled channel is visited in ascending index
// order: cleared, integrated for win_len cycles, read out through 2-bit I/Q
// lanes into shift registers, then the result is offered on a valid/ready port.
//
// Ports:
//   clk_master, rstb        clock, async active-low reset
//   start, abort            scan request (IDLE only) / synchronous abort
//   ch_mask, win_len        channel set and window length, latched on start
//   read_out_I/Q            per-channel 2-bit lanes, channel c on [2c+1:2c]
//   ch_clk_en/rstb/ud_en    per-channel clock gate, clear, count enable
//   busy, done              scan in progress / completion pulse
//   res_valid/ready         result handshake
//   res_ch, res_I, res_Q    result channel and captured words
module unison_scan_sequencer #(
  parameter int unsigned NUM_CH  = 6,
  parameter int unsigned WIN_W   = 16,
  parameter int unsigned RD_BITS = 16,
  parameter int unsigned CH_W    = 3
) (
  input  logic                   clk_master,
  input  logic                   rstb,
  input  logic                   start,
  input  logic                   abort,
  input  logic [NUM_CH-1:0]      ch_mask,
  input  logic [WIN_W-1:0]       win_len,
  input  logic [2*NUM_CH-1:0]    read_out_I,
  input  logic [2*NUM_CH-1:0]    read_out_Q,
  output logic [NUM_CH-1:0]      ch_clk_en,
  output logic [NUM_CH-1:0]      ch_rstb,
  output logic [NUM_CH-1:0]      ch_ud_en,
  output logic                   busy,
  output logic                   done,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [CH_W-1:0]        res_ch,
  output logic [2*RD_BITS-1:0]   res_I,
  output logic [2*RD_BITS-1:0]   res_Q
);

  localparam int unsigned RES_W    = 2 * RD_BITS;
  localparam int unsigned RD_CNT_W = $clog2(RD_BITS + 1);
  localparam int unsigned CNT_W    = (WIN_W > RD_CNT_W) ? WIN_W : RD_CNT_W;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_CLEAR, S_INTEGRATE, S_READ, S_HOLD
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [NUM_CH-1:0]   r_pend, w_pend_nxt;      // channels not yet visited
  logic [WIN_W-1:0]    r_win, w_win_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [CH_W-1:0]     r_cur, w_cur_nxt;
  logic [NUM_CH-1:0]   r_ch_clk_en, w_ch_clk_en_nxt;
  logic [NUM_CH-1:0]   r_ch_rstb, w_ch_rstb_nxt;
  logic [NUM_CH-1:0]   r_ch_ud_en, w_ch_ud_en_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_res_valid, w_res_valid_nxt;
  logic [RES_W-1:0]    r_res_i, w_res_i_nxt;
  logic [RES_W-1:0]    r_res_q, w_res_q_nxt;

  logic                w_found;
  logic [CH_W-1:0]     w_sel_idx;
  logic [1:0]          w_lane_i, w_lane_q;
  logic [NUM_CH-1:0]   w_oh;

  // State and all registered outputs.
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      r_state     <= S_IDLE;
      r_pend      <= '0;
      r_win       <= '0;
      r_cnt       <= '0;
      r_cur       <= '0;
      r_ch_clk_en <= '0;
      r_ch_rstb   <= '0;
      r_ch_ud_en  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_i     <= '0;
      r_res_q     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend      <= w_pend_nxt;
      r_win       <= w_win_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cur       <= w_cur_nxt;
      r_ch_clk_en <= w_ch_clk_en_nxt;
      r_ch_rstb   <= w_ch_rstb_nxt;
      r_ch_ud_en  <= w_ch_ud_en_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_res_i     <= w_res_i_nxt;
      r_res_q     <= w_res_q_nxt;
    end
  end

  // Next state, datapath and next-cycle output values.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_win_nxt   = r_win;
    w_cnt_nxt   = r_cnt;
    w_cur_nxt   = r_cur;
    w_done_nxt  = 1'b0;
    w_res_i_nxt = r_res_i;
    w_res_q_nxt = r_res_q;
    w_found     = 1'b0;
    w_sel_idx   = '0;
    w_lane_i    = '0;
    w_lane_q    = '0;

    // Descending scan so the lowest pending index is the one that sticks.
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (r_pend[c]) begin
        w_found   = 1'b1;
        w_sel_idx = CH_W'(c);
      end
    end

    for (int c = 0; c < NUM_CH; c++) begin
      if (r_cur == CH_W'(c)) begin
        w_lane_i = read_out_I[2*c +: 2];
        w_lane_q = read_out_Q[2*c +: 2];
      end
    end

    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_pend_nxt  = ch_mask;
          w_win_nxt   = (win_len == '0) ? WIN_W'(1) : win_len;
          w_state_nxt = S_SELECT;
        end
      end
      S_SELECT: begin
        if (w_found) begin
          w_cur_nxt   = w_sel_idx;
          w_pend_nxt  = r_pend & ~(NUM_CH'(1) << w_sel_idx);
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = S_CLEAR;
        end else begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_CLEAR: begin
        w_res_i_nxt = '0;
        w_res_q_nxt = '0;
        if (r_cnt == '0) begin
          w_cnt_nxt   = CNT_W'(r_win);
          w_state_nxt = S_INTEGRATE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_INTEGRATE: begin
        // Counts down to 1 from a value >= 1, so the full window never wraps.
        if (r_cnt == CNT_W'(1)) begin
          w_cnt_nxt   = CNT_W'(RD_BITS);
          w_state_nxt = S_READ;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_READ: begin
        w_res_i_nxt = {r_res_i[RES_W-3:0], w_lane_i};
        w_res_q_nxt = {r_res_q[RES_W-3:0], w_lane_q};
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          w_state_nxt = S_SELECT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_done_nxt  = 1'b0;
    end

    // Outputs are decoded from the upcoming state so they register in step with it.
    w_oh            = NUM_CH'(1) << w_cur_nxt;
    w_ch_clk_en_nxt = '0;
    w_ch_ud_en_nxt  = '0;
    w_ch_rstb_nxt   = '1;
    w_res_valid_nxt = 1'b0;
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    case (w_state_nxt)
      S_CLEAR:     w_ch_rstb_nxt = ~w_oh;
      S_INTEGRATE: begin
        w_ch_clk_en_nxt = w_oh;
        w_ch_ud_en_nxt  = w_oh;
      end
      S_READ:      w_ch_clk_en_nxt = w_oh;
      S_HOLD:      w_res_valid_nxt = 1'b1;
      default:     ;
    endcase
  end

  assign ch_clk_en = r_ch_clk_en;
  assign ch_rstb   = r_ch_rstb;
  assign ch_ud_en  = r_ch_ud_en;
  assign busy      = r_busy;
  assign done      = r_done;
  assign res_valid = r_res_valid;
  assign res_ch    = r_cur;
  assign res_I     = r_res_i;
  assign res_Q     = r_res_q;

endmodule

// File: tb/tb_unison_scan_sequencer.sv
// Directed bench for unison_scan_sequencer (NUM_CH=6, RD_BITS=4).
module tb_unison_scan_sequencer;

  localparam int unsigned NUM_CH  = 6;
  localparam int unsigned WIN_W   = 16;
  localparam int unsigned RD_BITS = 4;
  localparam int unsigned CH_W    = 3;

  logic                  clk_master = 1'b0;
  logic                  rstb;
  logic                  start;
  logic                  abort;
  logic [NUM_CH-1:0]     ch_mask;
  logic [WIN_W-1:0]      win_len;
  logic [2*NUM_CH-1:0]   read_out_I;
  logic [2*NUM_CH-1:0]   read_out_Q;
  logic [NUM_CH-1:0]     ch_clk_en;
  logic [NUM_CH-1:0]     ch_rstb;
  logic [NUM_CH-1:0]     ch_ud_en;
  logic                  busy;
  logic                  done;
  logic                  res_valid;
  logic                  res_ready;
  logic [CH_W-1:0]       res_ch;
  logic [2*RD_BITS-1:0]  res_I;
  logic [2*RD_BITS-1:0]  res_Q;

  unison_scan_sequencer #(
    .NUM_CH(NUM_CH), .WIN_W(WIN_W), .RD_BITS(RD_BITS), .CH_W(CH_W)
  ) u_dut (
    .clk_master(clk_master), .rstb(rstb), .start(start), .abort(abort),
    .ch_mask(ch_mask), .win_len(win_len),
    .read_out_I(read_out_I), .read_out_Q(read_out_Q),
    .ch_clk_en(ch_clk_en), .ch_rstb(ch_rstb), .ch_ud_en(ch_ud_en),
    .busy(busy), .done(done), .res_valid(res_valid), .res_ready(res_ready),
    .res_ch(res_ch), .res_I(res_I), .res_Q(res_Q)
  );

  always #5 clk_master = ~clk_master;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;
  int clk_cnt[NUM_CH];
  int ud_cnt[NUM_CH];
  int done_cnt;
  int valid_cnt;
  int oh_err;
  int bad;
  int other_clk;
  logic [1:0] q_tbl [4] = '{2'b01, 2'b01, 2'b10, 2'b11};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic clear_stats();
    for (int c = 0; c < NUM_CH; c++) begin
      clk_cnt[c] = 0;
      ud_cnt[c]  = 0;
    end
    done_cnt  = 0;
    valid_cnt = 0;
    oh_err    = 0;
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_master);
    #1;
    edge_n++;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_clk_en[c]) clk_cnt[c]++;
      if (ch_ud_en[c])  ud_cnt[c]++;
    end
    if ($countones(ch_clk_en) > 1) oh_err++;
    if (done)      done_cnt++;
    if (res_valid) valid_cnt++;
  endtask

  // Start edge becomes edge 0.
  task automatic start_scan(input logic [NUM_CH-1:0] mask, input logic [WIN_W-1:0] win);
    clear_stats();
    ch_mask = mask;
    win_len = win;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    edge_n  = 0;
  endtask

  // Lanes for the main scan: ch0 I pattern in its READ window, ch2 Q pattern
  // in its READ window, constant noise on channels 1 and 3.
  task automatic drive_main(input int k);
    read_out_I = '0;
    read_out_Q = '0;
    read_out_I[3:2] = 2'b11;
    read_out_Q[3:2] = 2'b10;
    read_out_I[7:6] = 2'b11;
    if (k >= 7 && k <= 10) read_out_I[1:0] = 2'(3 - (k - 7));
    if (k >= 19 && k <= 22) read_out_Q[5:4] = q_tbl[k - 19];
  endtask

  initial begin
    rstb = 1'b0; start = 1'b0; abort = 1'b0; ch_mask = '0; win_len = '0;
    read_out_I = '0; read_out_Q = '0; res_ready = 1'b0;
    clear_stats();

    // Reset values, then release away from an edge.
    repeat (2) @(posedge clk_master);
    #1;
    check("rst_ch_rstb", 32'(ch_rstb), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rstb = 1'b1;
    tick();
    check("post_rst_ch_rstb", 32'(ch_rstb), 32'h3F);

    // Reset asserted mid-INTEGRATE.
    start_scan(6'b000001, 16'd10);
    repeat (3) tick();
    check("int_clk_en", 32'(ch_clk_en), 32'h01);
    rstb = 1'b0;
    #1;
    check("midrst_ch_rstb", 32'(ch_rstb), 32'h0);
    check("midrst_clk_en", 32'(ch_clk_en), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    repeat (2) tick();
    rstb = 1'b1;
    clear_stats();
    tick();
    check("rel_ch_rstb", 32'(ch_rstb), 32'h3F);
    repeat (15) tick();
    check("rel_no_done", 32'(done_cnt), 32'h0);
    check("rel_idle", 32'(busy), 32'h0);

    // Main scan: mask 000101, win 4, ready always high.
    res_ready = 1'b1;
    start_scan(6'b000101, 16'd4);
    check("m_busy_e0", 32'(busy), 32'h1);
    drive_main(0);
    for (int k = 1; k <= 27; k++) begin
      tick();
      if (k == 1) check("m_clear0", 32'(ch_rstb), 32'h3E);
      if (k == 3) check("m_ud_int0", 32'(ch_ud_en), 32'h01);
      if (k == 7) check("m_read0_clk", 32'(ch_clk_en), 32'h01);
      if (k == 10) check("m_valid_e10", 32'(res_valid), 32'h0);
      if (k == 11) begin
        check("m_valid_e11", 32'(res_valid), 32'h1);
        check("m_ch0", 32'(res_ch), 32'h0);
        check("m_I0", 32'(res_I), 32'hE4);
        check("m_Q0", 32'(res_Q), 32'h00);
      end
      if (k == 12) check("m_valid_drop", 32'(res_valid), 32'h0);
      if (k == 13) check("m_clear2", 32'(ch_rstb), 32'h3B);
      if (k == 23) begin
        check("m_valid_e23", 32'(res_valid), 32'h1);
        check("m_ch2", 32'(res_ch), 32'h2);
        check("m_I2", 32'(res_I), 32'h00);
        check("m_Q2", 32'(res_Q), 32'h5B);
      end
      if (k == 25) begin
        check("m_done_e25", 32'(done), 32'h1);
        check("m_busy_e25", 32'(busy), 32'h0);
      end
      drive_main(k);
    end
    check("m_clk0_cycles", 32'(clk_cnt[0]), 32'd8);
    check("m_clk2_cycles", 32'(clk_cnt[2]), 32'd8);
    check("m_clk1_cycles", 32'(clk_cnt[1]), 32'd0);
    check("m_ud0_cycles", 32'(ud_cnt[0]), 32'd4);
    check("m_ud2_cycles", 32'(ud_cnt[2]), 32'd4);
    check("m_done_count", 32'(done_cnt), 32'd1);
    check("m_valid_count", 32'(valid_cnt), 32'd2);
    check("m_onehot", 32'(oh_err), 32'd0);

    // Empty mask.
    start_scan(6'b000000, 16'd4);
    check("e_busy_e0", 32'(busy), 32'h1);
    check("e_done_e0", 32'(done), 32'h0);
    tick();
    check("e_done_e1", 32'(done), 32'h1);
    check("e_busy_e1", 32'(busy), 32'h0);
    tick();
    check("e_done_e2", 32'(done), 32'h0);
    check("e_valid_count", 32'(valid_cnt), 32'd0);

    // Back-pressure in HOLD.
    res_ready  = 1'b0;
    read_out_I = '0;
    read_out_Q = '0;
    read_out_I[1:0] = 2'b01;
    read_out_I[3:2] = 2'b10;
    start_scan(6'b000011, 16'd2);
    repeat (9) tick();
    check("bp_valid", 32'(res_valid), 32'h1);
    check("bp_ch0", 32'(res_ch), 32'h0);
    check("bp_I0", 32'(res_I), 32'h55);
    read_out_I[1:0] = 2'b11;
    bad = 0;
    repeat (20) begin
      tick();
      if (!res_valid || res_ch != 3'd0 || res_I != 8'h55 || res_Q != 8'h00 || ch_clk_en != '0)
        bad++;
    end
    check("bp_stable", 32'(bad), 32'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp_xfer_drop", 32'(res_valid), 32'h0);
    repeat (9) tick();
    check("bp_valid1", 32'(res_valid), 32'h1);
    check("bp_ch1", 32'(res_ch), 32'h1);
    check("bp_I1", 32'(res_I), 32'hAA);
    res_ready = 1'b1;
    repeat (2) tick();
    check("bp_done", 32'(done), 32'h1);
    check("bp_valid_total", 32'(valid_cnt), 32'd22);

    // Abort during READ of channel 1, start asserted alongside.
    read_out_I = '0;
    read_out_I[3:2] = 2'b10;
    start_scan(6'b000010, 16'd3);
    repeat (7) tick();
    check("ab_read_clk", 32'(ch_clk_en), 32'h02);
    abort = 1'b1;
    start = 1'b1;
    clear_stats();
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("ab_busy", 32'(busy), 32'h0);
    check("ab_valid", 32'(res_valid), 32'h0);
    check("ab_clk_en", 32'(ch_clk_en), 32'h0);
    check("ab_ud_en", 32'(ch_ud_en), 32'h0);
    check("ab_ch_rstb", 32'(ch_rstb), 32'h3F);
    repeat (4) tick();
    check("ab_no_done", 32'(done_cnt), 32'd0);
    check("ab_no_restart", 32'(busy), 32'h0);
    start_scan(6'b000010, 16'd3);
    repeat (10) tick();
    check("ab2_valid", 32'(res_valid), 32'h1);
    check("ab2_ch", 32'(res_ch), 32'h1);
    check("ab2_I", 32'(res_I), 32'hAA);
    repeat (2) tick();
    check("ab2_done", 32'(done), 32'h1);

    // win_len = 0 runs one INTEGRATE cycle; start/mask/win while busy ignored.
    read_out_I = '0;
    read_out_I[1:0] = 2'b11;
    start_scan(6'b000001, 16'd0);
    repeat (2) tick();
    start   = 1'b1;
    ch_mask = 6'b111111;
    win_len = 16'd50;
    repeat (2) tick();
    start = 1'b0;
    repeat (4) tick();
    check("w0_valid_e8", 32'(res_valid), 32'h1);
    check("w0_I", 32'(res_I), 32'hFF);
    repeat (2) tick();
    check("w0_done_e10", 32'(done), 32'h1);
    check("w0_busy_e10", 32'(busy), 32'h0);
    check("w0_ud_cycles", 32'(ud_cnt[0]), 32'd1);
    check("w0_clk_cycles", 32'(clk_cnt[0]), 32'd5);
    other_clk = 0;
    for (int c = 1; c < NUM_CH; c++) other_clk += clk_cnt[c];
    check("w0_other_clk", 32'(other_clk), 32'd0);
    repeat (3) tick();
    check("w0_no_restart", 32'(busy), 32'h0);
    check("w0_done_count", 32'(done_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
